// File: rtl/prog_clock_divider.sv
// prog_clock_divider: per-channel programmable divider emitting tick strobes and 50% clk_out, with staged divisor loads
module prog_clock_divider #(
    parameter int CHANNELS = 4,
    parameter int WIDTH = 16,
    parameter int DEFAULT_DIV = 2,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                ld_valid,
    input  logic [CW-1:0]       ld_ch,
    input  logic [WIDTH-1:0]    ld_div,
    output logic                ld_ready,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clk_out
);
    logic [CHANNELS-1:0] pend_flag;
    always_comb begin
        ld_ready = 1'b0;
        for (int i = 0; i < CHANNELS; i++)
            if (ld_ch == CW'(i)) ld_ready = ~pend_flag[i];
    end
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] act_div, pend_div, count;
        logic tk, co, pf, ld_hit, term;
        assign ld_hit = ld_valid & ld_ready & (ld_ch == CW'(c));
        assign term = count == act_div - WIDTH'(1);
        assign tick[c] = tk;
        assign clk_out[c] = co;
        assign pend_flag[c] = pf;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_div <= WIDTH'(DEFAULT_DIV);
                pend_div <= '0;
                count <= '0;
                pf <= 1'b0;
                tk <= 1'b0;
                co <= 1'b0;
            end else begin
                // a disabled channel picks up a staged divisor regardless of en
                if (act_div == '0) begin
                    count <= '0;
                    tk <= 1'b0;
                    co <= 1'b0;
                    if (pf) begin
                        act_div <= pend_div;
                        pf <= 1'b0;
                    end
                end else if (en) begin
                    if (term) begin
                        count <= '0;
                        tk <= 1'b1;
                        co <= ~co;
                        if (pf) begin
                            act_div <= pend_div;
                            pf <= 1'b0;
                        end
                    end else begin
                        count <= count + WIDTH'(1);
                        tk <= 1'b0;
                    end
                end else begin
                    tk <= 1'b0;
                end
                // only accepted while nothing is pending, so never races the apply above
                if (ld_hit) begin
                    pend_div <= ld_div;
                    pf <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: scoreboard bench, expected tick cycles queued per channel and matched by a monitor
module tb_prog_clock_divider;
    logic clk = 0, rst_n = 0, en = 0, s_en = 0;
    logic ld_valid = 0, s_ld_valid = 0;
    logic [1:0] ld_ch = 0, s_ld_ch = 0;
    logic [15:0] ld_div = 0;
    logic [3:0] s_ld_div = 0;
    logic ld_ready, s_ld_ready;
    logic [3:0] tick, clk_out;
    logic [2:0] s_tick, s_clk_out;
    logic [6:0] tv;
    int checks = 0, errors = 0, cyc = 0, acc;
    bit mon_on = 0;
    int expq[7][$];

    prog_clock_divider u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ld_valid(ld_valid), .ld_ch(ld_ch),
        .ld_div(ld_div), .ld_ready(ld_ready), .tick(tick), .clk_out(clk_out)
    );

    prog_clock_divider #(.CHANNELS(3), .WIDTH(4), .DEFAULT_DIV(15)) u_small (
        .clk(clk), .rst_n(rst_n), .en(s_en), .ld_valid(s_ld_valid), .ld_ch(s_ld_ch),
        .ld_div(s_ld_div), .ld_ready(s_ld_ready), .tick(s_tick), .clk_out(s_clk_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d, t=%0t)", nm, act, exp, cyc, $time);
        end
    endtask

    // monitor: every tick seen must match the next expected cycle of its channel
    initial forever begin
        @(posedge clk);
        #2;
        if (mon_on) begin
            tv = {s_tick, tick};
            for (int i = 0; i < 7; i++)
                if (tv[i]) begin
                    if (expq[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tick%0d_unexpected: got tick at cyc %0d expected none", i, cyc);
                    end else chk($sformatf("tick%0d_cycle", i), cyc, expq[i].pop_front());
                end
        end
    end

    task automatic push(input int q, input int first, input int per, input int last);
        for (int t = first; t <= last; t += per) expq[q].push_back(t);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_empty();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("missing_ticks_ch%0d", i), expq[i].size(), 0);
            expq[i].delete();
        end
    endtask

    task automatic start_phase(input bit main_en, input bit small_en);
        @(negedge clk);
        mon_on = 0;
        rst_n = 0;
        ld_valid = 0;
        s_ld_valid = 0;
        en = main_en;
        s_en = small_en;
        repeat (2) @(negedge clk);
        rst_n = 1;
        mon_on = 1;
    endtask

    task automatic end_phase(input int n);
        run_to(n);
        mon_on = 0;
        check_empty();
    endtask

    task automatic do_load(input bit sm, input int ch, input int dv, output int a);
        bit r;
        a = -1;
        if (sm) begin
            s_ld_valid = 1; s_ld_ch = 2'(ch); s_ld_div = 4'(dv);
        end else begin
            ld_valid = 1; ld_ch = 2'(ch); ld_div = 16'(dv);
        end
        for (int i = 0; i < 64 && a < 0; i++) begin
            #1;
            r = sm ? s_ld_ready : ld_ready;
            @(negedge clk);
            if (r) a = cyc;
        end
        ld_valid = 0;
        s_ld_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_tick", tick, 0);
        chk("reset_clk_out", clk_out, 0);
        chk("reset_ld_ready", ld_ready, 1);
        chk("reset_s_clk_out", s_clk_out, 0);
        // defaults: divide by 2 on every channel
        start_phase(1, 0);
        for (int c = 0; c < 4; c++) push(c, 2, 2, 20);
        run_to(3);
        chk("dflt_clk_out_hi", clk_out, 4'hF);
        ld_ch = 3; #1 chk("dflt_ready_ch3", ld_ready, 1);
        run_to(5);
        chk("dflt_clk_out_lo", clk_out, 0);
        end_phase(20);
        // reprogram ch1 to 5 mid-period
        start_phase(1, 0);
        for (int c = 0; c < 4; c++) if (c != 1) push(c, 2, 2, 30);
        push(1, 2, 2, 6);
        push(1, 11, 5, 30);
        run_to(4);
        do_load(0, 1, 5, acc);
        chk("reprog_accept", acc, 5);
        ld_ch = 1; #1 chk("reprog_ready_ch1_pending", ld_ready, 0);
        ld_ch = 0; #1 chk("reprog_ready_ch0", ld_ready, 1);
        run_to(6);
        ld_ch = 1; #1 chk("reprog_ready_ch1_applied", ld_ready, 1);
        run_to(15);
        chk("reprog_clk_out1_lo", clk_out[1], 0);
        run_to(16);
        chk("reprog_clk_out1_hi", clk_out[1], 1);
        end_phase(30);
        // disable ch2 then re-enable at 3
        start_phase(1, 0);
        for (int c = 0; c < 4; c++) if (c != 2) push(c, 2, 2, 26);
        push(2, 2, 2, 6);
        push(2, 17, 3, 26);
        run_to(4);
        do_load(0, 2, 0, acc);
        chk("dis_accept", acc, 5);
        run_to(6);
        chk("dis_last_toggle", clk_out[2], 1);
        run_to(7);
        chk("dis_clk_out_zero", clk_out[2], 0);
        run_to(12);
        do_load(0, 2, 3, acc);
        chk("reen_accept", acc, 13);
        ld_ch = 2; #1 chk("reen_ready_pending", ld_ready, 0);
        run_to(16);
        chk("reen_clk_out_still_lo", clk_out[2], 0);
        run_to(17);
        chk("reen_clk_out_hi", clk_out[2], 1);
        end_phase(26);
        // collision on terminal edge, then back-pressured second load
        start_phase(1, 0);
        for (int c = 1; c < 4; c++) push(c, 2, 2, 30);
        push(0, 2, 2, 8);
        push(0, 15, 3, 30);
        run_to(5);
        do_load(0, 0, 7, acc);
        chk("coll_accept", acc, 6);
        ld_ch = 0; #1 chk("coll_ready_blocked", ld_ready, 0);
        do_load(0, 0, 3, acc);
        chk("stall_accept", acc, 9);
        end_phase(30);
        // gating: en low for 10 edges
        start_phase(1, 0);
        for (int c = 0; c < 4; c++) begin
            push(c, 2, 2, 2);
            push(c, 14, 2, 20);
        end
        run_to(3);
        en = 0;
        run_to(8);
        chk("gate_clk_out_frozen_a", clk_out, 4'hF);
        run_to(13);
        chk("gate_clk_out_frozen_b", clk_out, 4'hF);
        en = 1;
        run_to(14);
        chk("gate_resume_toggle", clk_out, 0);
        end_phase(20);
        // reset with a pending load
        start_phase(1, 0);
        for (int c = 0; c < 4; c++) push(c, 2, 2, 2);
        run_to(2);
        do_load(0, 1, 5, acc);
        chk("rst_load_accept", acc, 3);
        rst_n = 0;
        #1;
        chk("rst_async_clk_out", clk_out, 0);
        chk("rst_async_tick", tick, 0);
        ld_ch = 1; #1 chk("rst_ready_cleared", ld_ready, 1);
        mon_on = 0;
        check_empty();
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 4; c++) push(c, 2, 2, 20);
        mon_on = 1;
        end_phase(20);
        // extremes on the 4-bit, 3-channel instance
        start_phase(0, 1);
        push(4, 15, 15, 45);
        push(6, 15, 15, 45);
        push(5, 15, 15, 30);
        push(5, 31, 1, 45);
        run_to(14);
        chk("ext_clk_out_pre", s_clk_out, 0);
        run_to(15);
        chk("ext_clk_out_d15", s_clk_out, 3'b111);
        run_to(20);
        do_load(1, 1, 1, acc);
        chk("ext_accept_d1", acc, 21);
        run_to(22);
        s_ld_valid = 1; s_ld_ch = 3; s_ld_div = 4;
        #1 chk("ext_oor_ready", s_ld_ready, 0);
        run_to(24);
        s_ld_valid = 0;
        run_to(33);
        chk("ext_d1_clk_out_a", s_clk_out[1], 1);
        run_to(34);
        chk("ext_d1_clk_out_b", s_clk_out[1], 0);
        end_phase(45);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
